// File: rtl/ahb_tick_scheduler.sv
// ahb_tick_scheduler
// AHB3-Lite master that re-arms an ACLINT MTIMER as a periodic tick source.
// On timeout it reads MTIMECMP (lo, hi), adds the programmed period and
// writes the 64-bit result back (lo, hi), then emits a one-cycle tick.
// Optional feature macro: AHB_TICK_SCHED_PARITY_EN enables m_hparity_o
// generation; when undefined m_hparity_o is tied to zero.
module ahb_tick_scheduler #(
  parameter logic [31:0] TIMER_BASE = 32'h0
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        enable_i,
  input  logic [31:0] period_i,
  input  logic        err_clr_i,
  input  logic        timeout_i,
  output logic [31:0] m_haddr_o,
  output logic [31:0] m_hwdata_o,
  output logic [2:0]  m_hburst_o,
  output logic        m_hmastlock_o,
  output logic [3:0]  m_hprot_o,
  output logic [2:0]  m_hsize_o,
  output logic [1:0]  m_htrans_o,
  output logic        m_hwrite_o,
  output logic [5:0]  m_hparity_o,
  input  logic [31:0] m_hrdata_i,
  input  logic        m_hready_i,
  input  logic        m_hresp_i,
  output logic        tick_o,
  output logic [31:0] tick_cnt_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [31:0] ADDR_LO      = TIMER_BASE + 32'd8;
  localparam logic [31:0] ADDR_HI      = TIMER_BASE + 32'd12;
  localparam logic [1:0]  HTRANS_IDLE  = 2'b00;
  localparam logic [1:0]  HTRANS_NSEQ  = 2'b10;
  localparam logic [2:0]  HBURST_SINGLE = 3'b000;
  localparam logic [2:0]  HSIZE_WORD   = 3'b010;
  localparam logic [3:0]  HPROT_DATA   = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RLO  = 3'd1,
    S_RHI  = 3'd2,
    S_WLO  = 3'd3,
    S_WHI  = 3'd4,
    S_WDAT = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_e;

  state_e       state_q, state_d;
  logic         err_q, err_d;
  logic [31:0]  tick_cnt_q, tick_cnt_d;
  logic [31:0]  period_q, period_d;
  logic [31:0]  lo_q, lo_d;
  logic [63:0]  sum_q, sum_d;

  logic         data_phase;
  logic         bus_err;

  // A period of zero would never advance MTIMECMP; saturate it to one tick.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

  // 64-bit compare value plus zero-extended period, wrapping modulo 2^64.
  function automatic logic [63:0] add_period(input logic [31:0] hi,
                                             input logic [31:0] lo,
                                             input logic [31:0] p);
    return {hi, lo} + {32'd0, p};
  endfunction

  // Byte-wise even parity of a 32-bit address, byte n in bit n.
  function automatic logic [3:0] addr_parity(input logic [31:0] a);
    return {^a[31:24], ^a[23:16], ^a[15:8], ^a[7:0]};
  endfunction

  // States that carry the data phase of one of our own transfers.
  assign data_phase = (state_q == S_RHI) || (state_q == S_WLO) ||
                      (state_q == S_WHI) || (state_q == S_WDAT);

  // First cycle of a two-cycle AHB error response.
  assign bus_err = data_phase && m_hresp_i && !m_hready_i;

  assign m_hburst_o    = HBURST_SINGLE;
  assign m_hmastlock_o = 1'b0;
  assign m_hprot_o     = HPROT_DATA;
  assign m_hsize_o     = HSIZE_WORD;

  assign tick_o     = (state_q == S_DONE);
  assign tick_cnt_o = tick_cnt_q;
  assign busy_o     = (state_q != S_IDLE);
  assign err_o      = err_q;

  // Address/control from state; htrans is cancelled in the error cycle so no
  // further transfer follows a failing one.
  always_comb begin
    m_htrans_o = HTRANS_IDLE;
    m_haddr_o  = ADDR_LO;
    m_hwrite_o = 1'b0;
    unique case (state_q)
      S_RLO: begin
        m_htrans_o = HTRANS_NSEQ;
        m_haddr_o  = ADDR_LO;
        m_hwrite_o = 1'b0;
      end
      S_RHI: begin
        m_htrans_o = HTRANS_NSEQ;
        m_haddr_o  = ADDR_HI;
        m_hwrite_o = 1'b0;
      end
      S_WLO: begin
        m_htrans_o = HTRANS_NSEQ;
        m_haddr_o  = ADDR_LO;
        m_hwrite_o = 1'b1;
      end
      S_WHI: begin
        m_htrans_o = HTRANS_NSEQ;
        m_haddr_o  = ADDR_HI;
        m_hwrite_o = 1'b1;
      end
      default: begin
        m_htrans_o = HTRANS_IDLE;
        m_haddr_o  = ADDR_LO;
        m_hwrite_o = 1'b0;
      end
    endcase
    if (bus_err) begin
      m_htrans_o = HTRANS_IDLE;
    end
  end

  // Write data follows the write address phases by one cycle and is held
  // from registered state, so it stays stable across wait states.
  always_comb begin
    m_hwdata_o = 32'd0;
    if (state_q == S_WHI) begin
      m_hwdata_o = sum_q[31:0];
    end else if (state_q == S_WDAT) begin
      m_hwdata_o = sum_q[63:32];
    end
  end

`ifdef AHB_TICK_SCHED_PARITY_EN
  // Parity over address and control as driven on the bus this cycle.
  always_comb begin
    m_hparity_o[3:0] = addr_parity(m_haddr_o);
    m_hparity_o[4]   = (^m_hsize_o) ^ (^m_hburst_o) ^ (^m_hprot_o) ^
                       m_hwrite_o ^ m_hmastlock_o;
    m_hparity_o[5]   = ^m_htrans_o;
  end
`else
  // Parity generation disabled in this build.
  always_comb begin
    m_hparity_o = 6'b0;
    if (1'b0) begin
      m_hparity_o[3:0] = addr_parity(m_haddr_o);
    end
  end
`endif

  // Sequencer next state, captured data and counters.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    tick_cnt_d = tick_cnt_q;
    period_d   = period_q;
    lo_d       = lo_q;
    sum_d      = sum_q;

    if (err_clr_i) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable_i && timeout_i && !err_q) begin
          state_d  = S_RLO;
          period_d = clamp_period(period_i);
        end
      end
      S_RLO: begin
        if (m_hready_i) begin
          state_d = S_RHI;
        end
      end
      S_RHI: begin
        if (bus_err) begin
          state_d = S_ERR;
        end else if (m_hready_i) begin
          state_d = S_WLO;
          lo_d    = m_hrdata_i;
        end
      end
      S_WLO: begin
        if (bus_err) begin
          state_d = S_ERR;
        end else if (m_hready_i) begin
          state_d = S_WHI;
          sum_d   = add_period(m_hrdata_i, lo_q, period_q);
        end
      end
      S_WHI: begin
        if (bus_err) begin
          state_d = S_ERR;
        end else if (m_hready_i) begin
          state_d = S_WDAT;
        end
      end
      S_WDAT: begin
        if (bus_err) begin
          state_d = S_ERR;
        end else if (m_hready_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        tick_cnt_d = tick_cnt_q + 32'd1;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new error wins over a simultaneous clear.
    if (bus_err) begin
      err_d = 1'b1;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      state_q    <= S_IDLE;
      err_q      <= 1'b0;
      tick_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Datapath registers; only ever consumed after being loaded by a sequence.
  always_ff @(posedge s_clk_i) begin
    period_q <= period_d;
    lo_q     <= lo_d;
    sum_q    <= sum_d;
  end

endmodule

// File: tb/tb_ahb_tick_scheduler.sv
// Directed testbench for ahb_tick_scheduler with a small AHB MTIMER slave
// model (MTIMECMP registers, programmable wait states, error injection).
module tb_ahb_tick_scheduler;

  localparam logic [31:0] BASE = 32'h0200_4000;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [31:0] period;
  logic        err_clr;
  logic        timeout;
  logic [31:0] haddr, hwdata, hrdata;
  logic [2:0]  hburst, hsize;
  logic        hmastlock, hwrite, hready, hresp;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [5:0]  hparity;
  logic        tick, busy, err;
  logic [31:0] tick_cnt;

  // Timer / slave model state
  logic [63:0] mtime;
  logic [63:0] cmp;
  logic [63:0] ld_val;
  logic        ld_req;
  logic        err_arm;
  int          waits;
  logic        dp_valid;
  logic [31:0] dp_addr;
  logic        dp_write;
  int          wcnt;
  logic [1:0]  err_ph;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  int          wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int stab_err = 0;

  ahb_tick_scheduler #(.TIMER_BASE(BASE)) dut (
    .s_clk_i      (clk),
    .s_resetn_i   (resetn),
    .enable_i     (enable),
    .period_i     (period),
    .err_clr_i    (err_clr),
    .timeout_i    (timeout),
    .m_haddr_o    (haddr),
    .m_hwdata_o   (hwdata),
    .m_hburst_o   (hburst),
    .m_hmastlock_o(hmastlock),
    .m_hprot_o    (hprot),
    .m_hsize_o    (hsize),
    .m_htrans_o   (htrans),
    .m_hwrite_o   (hwrite),
    .m_hparity_o  (hparity),
    .m_hrdata_i   (hrdata),
    .m_hready_i   (hready),
    .m_hresp_i    (hresp),
    .tick_o       (tick),
    .tick_cnt_o   (tick_cnt),
    .busy_o       (busy),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign timeout = (cmp <= mtime);
  assign hready  = !dp_valid ? 1'b1 :
                   (err_ph == 2'd1) ? 1'b0 :
                   (err_ph == 2'd2) ? 1'b1 : (wcnt == 0);
  assign hresp   = dp_valid && (err_ph != 2'd0);
  assign hrdata  = (dp_addr == BASE + 32'd12) ? cmp[63:32] : cmp[31:0];

  // AHB slave model: one outstanding data phase, writes land on completion.
  always @(posedge clk) begin
    if (!resetn) begin
      dp_valid <= 1'b0;
      err_ph   <= 2'd0;
    end else if (ld_req) begin
      cmp      <= ld_val;
      wr_cnt   <= 0;
      dp_valid <= 1'b0;
      err_ph   <= 2'd0;
    end else if (dp_valid && err_ph == 2'd1) begin
      err_ph <= 2'd2;
    end else if (dp_valid && !hready) begin
      wcnt <= wcnt - 1;
    end else begin
      if (dp_valid && err_ph == 2'd0 && dp_write) begin
        if (dp_addr == BASE + 32'd8) cmp[31:0] <= hwdata;
        else cmp[63:32] <= hwdata;
        if (wr_cnt < 8) begin
          wr_addr[wr_cnt] <= dp_addr;
          wr_data[wr_cnt] <= hwdata;
        end
        wr_cnt <= wr_cnt + 1;
      end
      if (htrans == 2'b10) begin
        dp_valid <= 1'b1;
        dp_addr  <= haddr;
        dp_write <= hwrite;
        wcnt     <= waits;
        err_ph   <= (err_arm && haddr == BASE + 32'd12 && !hwrite) ? 2'd1 : 2'd0;
      end else begin
        dp_valid <= 1'b0;
        err_ph   <= 2'd0;
      end
    end
  end

  // Bus signals must not move while the slave is stretching a data phase.
  logic        snap_v;
  logic [31:0] snap_addr, snap_wd;
  logic [1:0]  snap_tr;
  logic        snap_wr;
  initial snap_v = 1'b0;
  always @(negedge clk) begin
    if (resetn && snap_v &&
        !(haddr == snap_addr && htrans == snap_tr && hwrite == snap_wr && hwdata == snap_wd))
      stab_err = stab_err + 1;
    snap_v    = resetn && !hready && !hresp;
    snap_addr = haddr;
    snap_tr   = htrans;
    snap_wr   = hwrite;
    snap_wd   = hwdata;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests = n_tests + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [63:0] c);
    @(negedge clk);
    ld_val = c;
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  // Count cycles (cycle 1 follows the edge that samples timeout) until tick.
  task automatic run_seq(input int start, output int cyc);
    cyc = start;
    while (cyc < 100) begin
      @(posedge clk);
      cyc = cyc + 1;
      @(negedge clk);
      if (tick) break;
    end
  endtask

  // Arm a fresh sequence: MTIMECMP=c, period p, timeout rises on return.
  task automatic arm(input logic [63:0] c, input logic [31:0] p, input logic [63:0] t);
    enable = 1'b0;
    mtime  = 64'd0;
    preset(c);
    period = p;
    enable = 1'b1;
    @(negedge clk);
    mtime = t;
  endtask

  initial begin
    int cyc;
    int ticks;
    logic found;
    resetn = 1'b0; enable = 1'b0; period = 32'd0; err_clr = 1'b0;
    mtime = 64'd0; ld_val = 64'd0; ld_req = 1'b0; err_arm = 1'b0; waits = 0;
    cmp = 64'hFFFF_FFFF_FFFF_FFFF; wr_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state
    check_eq("rst_htrans", htrans, 2'b00);
    check_eq("rst_hwrite", hwrite, 1'b0);
    check_eq("rst_haddr", haddr, BASE + 32'd8);
    check_eq("rst_hwdata", hwdata, 32'd0);
    check_eq("rst_tick", tick, 1'b0);
    check_eq("rst_tick_cnt", tick_cnt, 32'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("const_ctrl", {hburst, hmastlock, hprot, hsize}, {3'b000, 1'b0, 4'b0011, 3'b010});
`ifdef AHB_TICK_SCHED_PARITY_EN
    check_eq("rst_parity", hparity, 6'h1B);
`else
    check_eq("rst_parity", hparity, 6'h00);
`endif

    // Basic re-arm, zero waits
    arm(64'h100, 32'h40, 64'h100);
    run_seq(0, cyc);
    check_eq("t1_tick_cycle", cyc, 6);
    @(negedge clk);
    check_eq("t1_tick_cnt", tick_cnt, 32'd1);
    check_eq("t1_busy", busy, 1'b0);
    check_eq("t1_wr_cnt", wr_cnt, 2);
    check_eq("t1_wr0_addr", wr_addr[0], BASE + 32'd8);
    check_eq("t1_wr0_data", wr_data[0], 32'h140);
    check_eq("t1_wr1_addr", wr_addr[1], BASE + 32'd12);
    check_eq("t1_wr1_data", wr_data[1], 32'h0);
    check_eq("t1_timeout", timeout, 1'b0);

    // 64-bit wrap, enable dropped in cycle 1
    enable = 1'b0;
    preset(64'hFFFF_FFFF_FFFF_FFF0);
    period = 32'h20;
    mtime  = 64'hFFFF_FFFF_FFFF_FFF8;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t2_busy_c1", busy, 1'b1);
    enable = 1'b0;
    run_seq(1, cyc);
    check_eq("t2_tick_cycle", cyc, 6);
    @(negedge clk);
    check_eq("t2_tick_cnt", tick_cnt, 32'd2);
    check_eq("t2_wr0_data", wr_data[0], 32'h10);
    check_eq("t2_wr1_data", wr_data[1], 32'h0);
    repeat (10) @(negedge clk);
    check_eq("t2_no_restart_busy", busy, 1'b0);
    check_eq("t2_no_restart_cnt", tick_cnt, 32'd2);

    // Two wait states on every transfer
    waits = 2;
    arm(64'h100, 32'h40, 64'h100);
    run_seq(0, cyc);
    check_eq("t3_tick_cycle", cyc, 14);
    @(negedge clk);
    check_eq("t3_tick_cnt", tick_cnt, 32'd3);
    check_eq("t3_wr0_data", wr_data[0], 32'h140);
    check_eq("t3_wr1_data", wr_data[1], 32'h0);
    check_eq("t3_stable", stab_err, 0);
    waits = 0;

    // Error on the hi read
    err_arm = 1'b1;
    arm(64'h100, 32'h40, 64'h100);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hresp && !hready) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t4_err_seen", found, 1'b1);
    check_eq("t4_err_htrans", htrans, 2'b00);
    @(negedge clk);
    check_eq("t4_err_o", err, 1'b1);
    check_eq("t4_busy_err", busy, 1'b1);
    err_arm = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("t4_no_writes", wr_cnt, 0);
    check_eq("t4_blocked_busy", busy, 1'b0);
    check_eq("t4_cnt_held", tick_cnt, 32'd3);
    check_eq("t4_err_sticky", err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("t4_err_cleared", err, 1'b0);
    run_seq(0, cyc);
    check_eq("t4_resume_cycle", cyc, 6);
    @(negedge clk);
    check_eq("t4_resume_cnt", tick_cnt, 32'd4);
    check_eq("t4_resume_wr0", wr_data[0], 32'h140);

    // Zero period clamps to one; catch-up runs back to back
    arm(64'h100, 32'h0, 64'h103);
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick) ticks = ticks + 1;
    end
    check_eq("t5_ticks", ticks, 4);
    check_eq("t5_cmp", cmp, 64'h104);
    check_eq("t5_tick_cnt", tick_cnt, 32'd8);
    check_eq("t5_timeout", timeout, 1'b0);
    check_eq("t5_wr6_data", wr_data[6], 32'h104);

    // Reset during WLO
    arm(64'h100, 32'h40, 64'h100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("t6_wlo_ctrl", {htrans, hwrite}, {2'b10, 1'b1});
    enable = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check_eq("t6_htrans", htrans, 2'b00);
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_tick_cnt", tick_cnt, 32'd0);
    check_eq("t6_err", err, 1'b0);
    check_eq("t6_haddr", haddr, BASE + 32'd8);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
